// File: rtl/matrix_operand_fetcher_pkg.sv
// matrix_pkg: shared types and width helpers for the matrix operand fetcher.
//   fetch_state_t : walk controller states
//   idx_w()       : bit width needed to index n items (never below 1)
//   lanes_ok()    : legality of a (K, LANES) pairing
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  function automatic int idx_w(input int n);
    if (n <= 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // LANES must lie in 1..K and divide K so every beat stays inside one dot product.
  function automatic bit lanes_ok(input int k, input int lanes);
    return (lanes >= 32'sd1) && (lanes <= k) && ((k % lanes) == 32'sd0);
  endfunction

endpackage

// File: rtl/matrix_operand_fetcher_addr_gen.sv
// mof_addr_gen: i/j/k walk counters and A/B element address generation.
//   clk, rst     : clock, asynchronous active-high reset
//   clear        : zero all counters (new walk)
//   run          : walk is in its fetch phase
//   stall        : hold off issuing this cycle
//   col_major    : latched B layout (0 row-major, 1 column-major)
//   issue        : a read pair is issued this cycle
//   last_addr    : current address is (A_ROWS-1, B_COLS-1, K-1)
//   a_addr/b_addr: element addresses for the current (i,j,k)
//   row/col/lane : current i, j and k mod LANES
//   k_last       : current k is K-1
module mof_addr_gen
  import matrix_pkg::*;
#(
  parameter int A_ROWS = 8,
  parameter int K      = 8,
  parameter int B_COLS = 8,
  parameter int LANES  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            run,
  input  logic                            stall,
  input  logic                            col_major,
  output logic                            issue,
  output logic                            last_addr,
  output logic [idx_w(A_ROWS*K)-1:0]      a_addr,
  output logic [idx_w(K*B_COLS)-1:0]      b_addr,
  output logic [idx_w(A_ROWS)-1:0]        row,
  output logic [idx_w(B_COLS)-1:0]        col,
  output logic [idx_w(LANES)-1:0]         lane,
  output logic                            k_last
);

  localparam int AAW = idx_w(A_ROWS*K);
  localparam int BAW = idx_w(K*B_COLS);
  localparam int RW  = idx_w(A_ROWS);
  localparam int CW  = idx_w(B_COLS);
  localparam int KW  = idx_w(K);
  localparam int LW  = idx_w(LANES);

  logic [RW-1:0] i_q, i_d;
  logic [CW-1:0] j_q, j_d;
  logic [KW-1:0] k_q, k_d;
  logic [LW-1:0] lane_q, lane_d;
  logic          i_max_s, j_max_s, k_max_s;

  // Counter advance: k innermost, carrying into j then i, all wrapping to zero.
  always_comb begin
    issue   = run && !stall;
    i_max_s = (i_q == RW'(A_ROWS - 1));
    j_max_s = (j_q == CW'(B_COLS - 1));
    k_max_s = (k_q == KW'(K - 1));
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    lane_d  = lane_q;
    if (clear) begin
      i_d    = {RW{1'b0}};
      j_d    = {CW{1'b0}};
      k_d    = {KW{1'b0}};
      lane_d = {LW{1'b0}};
    end else if (issue) begin
      if (k_max_s) begin
        k_d    = {KW{1'b0}};
        lane_d = {LW{1'b0}};
        if (j_max_s) begin
          j_d = {CW{1'b0}};
          if (i_max_s) begin
            i_d = {RW{1'b0}};
          end else begin
            i_d = i_q + RW'(1'b1);
          end
        end else begin
          j_d = j_q + CW'(1'b1);
        end
      end else begin
        k_d = k_q + KW'(1'b1);
        if (lane_q == LW'(LANES - 1)) begin
          lane_d = {LW{1'b0}};
        end else begin
          lane_d = lane_q + LW'(1'b1);
        end
      end
    end else begin
      k_d = k_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q    <= {RW{1'b0}};
      j_q    <= {CW{1'b0}};
      k_q    <= {KW{1'b0}};
      lane_q <= {LW{1'b0}};
    end else begin
      i_q    <= i_d;
      j_q    <= j_d;
      k_q    <= k_d;
      lane_q <= lane_d;
    end
  end

  // Address math at full address width; the shape guarantees no overflow.
  always_comb begin
    a_addr = AAW'(i_q) * AAW'(K) + AAW'(k_q);
    if (col_major) begin
      b_addr = BAW'(j_q) * BAW'(K) + BAW'(k_q);
    end else begin
      b_addr = BAW'(k_q) * BAW'(B_COLS) + BAW'(j_q);
    end
  end

  assign row       = i_q;
  assign col       = j_q;
  assign lane      = lane_q;
  assign k_last    = k_max_s;
  assign last_addr = i_max_s && j_max_s && k_max_s;

endmodule

// File: rtl/matrix_operand_fetcher.sv
// matrix_operand_fetcher: walks A (A_ROWS x K) and B (K x B_COLS) and streams
// LANES-wide operand beats tagged with (i,j) and end-of-dot-product.
//   clk, rst            : clock, asynchronous active-high reset
//   start, b_col_major  : walk kick and B layout (sampled on start)
//   busy, done          : walk in progress, one-cycle completion pulse
//   a_rd_*, b_rd_*      : memory read ports, data one cycle after enable
//   out_valid/out_ready : beat handshake
//   out_a, out_b        : lane n in bits [n*DATA_W +: DATA_W]
//   out_row, out_col    : (i,j) tag; out_last marks the final beat of (i,j)
module matrix_operand_fetcher
  import matrix_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int A_ROWS = 8,
  parameter int K      = 8,
  parameter int B_COLS = 8,
  parameter int LANES  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          b_col_major,
  output logic                          busy,
  output logic                          done,
  output logic                          a_rd_en,
  output logic [idx_w(A_ROWS*K)-1:0]    a_rd_addr,
  input  logic [DATA_W-1:0]             a_rd_data,
  output logic                          b_rd_en,
  output logic [idx_w(K*B_COLS)-1:0]    b_rd_addr,
  input  logic [DATA_W-1:0]             b_rd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_W-1:0]       out_a,
  output logic [LANES*DATA_W-1:0]       out_b,
  output logic [idx_w(A_ROWS)-1:0]      out_row,
  output logic [idx_w(B_COLS)-1:0]      out_col,
  output logic                          out_last
);

  localparam int RW = idx_w(A_ROWS);
  localparam int CW = idx_w(B_COLS);
  localparam int LW = idx_w(LANES);
  localparam int BW = LANES * DATA_W;

  if (!lanes_ok(K, LANES)) begin : g_bad_lanes
    $error("matrix_operand_fetcher: LANES must lie in 1..K and divide K");
  end

  fetch_state_t state_q, state_d;
  logic         mode_q, mode_d;

  logic          issue_s, last_addr_s, k_last_s, stall_s, clear_s, run_s;
  logic [RW-1:0] row_s;
  logic [CW-1:0] col_s;
  logic [LW-1:0] lane_s;

  // In-flight read descriptor (data arrives the cycle after issue).
  logic          rd_pend_q, rd_pend_d;
  logic [LW-1:0] rd_lane_q, rd_lane_d;
  logic [RW-1:0] rd_row_q, rd_row_d;
  logic [CW-1:0] rd_col_q, rd_col_d;
  logic          rd_last_q, rd_last_d;

  // Collect buffer; buf_full_q means it holds a complete beat waiting for the output register.
  logic [BW-1:0] buf_a_q, buf_a_d, buf_b_q, buf_b_d;
  logic          buf_full_q, buf_full_d;
  logic [RW-1:0] buf_row_q, buf_row_d;
  logic [CW-1:0] buf_col_q, buf_col_d;
  logic          buf_last_q, buf_last_d;

  logic          out_valid_q, out_valid_d;
  logic [BW-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic [RW-1:0] out_row_q, out_row_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic          out_last_q, out_last_d;

  logic          out_free_s, complete_s, final_hs_s;

  assign clear_s = (state_q == IDLE) && start;
  assign run_s   = (state_q == FETCH);

  mof_addr_gen #(
    .A_ROWS (A_ROWS),
    .K      (K),
    .B_COLS (B_COLS),
    .LANES  (LANES)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_s),
    .run       (run_s),
    .stall     (stall_s),
    .col_major (mode_q),
    .issue     (issue_s),
    .last_addr (last_addr_s),
    .a_addr    (a_rd_addr),
    .b_addr    (b_rd_addr),
    .row       (row_s),
    .col       (col_s),
    .lane      (lane_s),
    .k_last    (k_last_s)
  );

  // Walk controller: next state and layout latch.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    final_hs_s = out_valid_q && out_ready && out_last_q &&
                 (out_row_q == RW'(A_ROWS - 1)) && (out_col_q == CW'(B_COLS - 1));
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          mode_d  = b_col_major;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (issue_s && last_addr_s) begin
          state_d = DRAIN;
        end else begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (final_hs_s) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // In-flight read tracking.
  always_comb begin
    rd_pend_d = issue_s;
    if (issue_s) begin
      rd_lane_d = lane_s;
      rd_row_d  = row_s;
      rd_col_d  = col_s;
      rd_last_d = k_last_s;
    end else begin
      rd_lane_d = rd_lane_q;
      rd_row_d  = rd_row_q;
      rd_col_d  = rd_col_q;
      rd_last_d = rd_last_q;
    end
  end

  // Beat assembly: fill lanes, bypass a just-completed beat straight into the
  // output register when it is free, otherwise park it in the buffer. A read
  // is only issued if the buffer will have room when its data returns.
  always_comb begin
    out_free_s  = !out_valid_q || out_ready;
    complete_s  = rd_pend_q && (rd_lane_q == LW'(LANES - 1));
    buf_a_d     = buf_a_q;
    buf_b_d     = buf_b_q;
    buf_full_d  = buf_full_q;
    buf_row_d   = buf_row_q;
    buf_col_d   = buf_col_q;
    buf_last_d  = buf_last_q;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_last_d  = out_last_q;

    for (int n = 0; n < LANES; n++) begin
      if (rd_pend_q && (rd_lane_q == LW'(n))) begin
        buf_a_d[n*DATA_W +: DATA_W] = a_rd_data;
        buf_b_d[n*DATA_W +: DATA_W] = b_rd_data;
      end else begin
        buf_a_d[n*DATA_W +: DATA_W] = buf_a_q[n*DATA_W +: DATA_W];
        buf_b_d[n*DATA_W +: DATA_W] = buf_b_q[n*DATA_W +: DATA_W];
      end
    end

    if (buf_full_q) begin
      if (out_free_s) begin
        out_valid_d = 1'b1;
        out_a_d     = buf_a_q;
        out_b_d     = buf_b_q;
        out_row_d   = buf_row_q;
        out_col_d   = buf_col_q;
        out_last_d  = buf_last_q;
        buf_full_d  = 1'b0;
      end else begin
        buf_full_d  = 1'b1;
      end
    end else if (complete_s) begin
      if (out_free_s) begin
        out_valid_d = 1'b1;
        out_a_d     = buf_a_d;
        out_b_d     = buf_b_d;
        out_row_d   = rd_row_q;
        out_col_d   = rd_col_q;
        out_last_d  = rd_last_q;
        buf_full_d  = 1'b0;
      end else begin
        buf_full_d  = 1'b1;
        buf_row_d   = rd_row_q;
        buf_col_d   = rd_col_q;
        buf_last_d  = rd_last_q;
      end
    end else begin
      buf_full_d = 1'b0;
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end

    stall_s = buf_full_d;
  end

  // State, read-tracking, buffer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_lane_q   <= {LW{1'b0}};
      rd_row_q    <= {RW{1'b0}};
      rd_col_q    <= {CW{1'b0}};
      rd_last_q   <= 1'b0;
      buf_a_q     <= {BW{1'b0}};
      buf_b_q     <= {BW{1'b0}};
      buf_full_q  <= 1'b0;
      buf_row_q   <= {RW{1'b0}};
      buf_col_q   <= {CW{1'b0}};
      buf_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_a_q     <= {BW{1'b0}};
      out_b_q     <= {BW{1'b0}};
      out_row_q   <= {RW{1'b0}};
      out_col_q   <= {CW{1'b0}};
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      rd_pend_q   <= rd_pend_d;
      rd_lane_q   <= rd_lane_d;
      rd_row_q    <= rd_row_d;
      rd_col_q    <= rd_col_d;
      rd_last_q   <= rd_last_d;
      buf_a_q     <= buf_a_d;
      buf_b_q     <= buf_b_d;
      buf_full_q  <= buf_full_d;
      buf_row_q   <= buf_row_d;
      buf_col_q   <= buf_col_d;
      buf_last_q  <= buf_last_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy      = (state_q == FETCH) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign a_rd_en   = issue_s;
  assign b_rd_en   = issue_s;
  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_matrix_operand_fetcher.sv
// Bench for matrix_operand_fetcher: three instances (LANES = 2, 1, 4) on a
// 2x4 by 4x3 problem with A[i][k]=10i+k and B[k][j]=100k+j. Expected beats are
// generated from the matrix definition and queued when a walk is started; a
// per-instance monitor pops and compares on every handshake.
module tb_matrix_operand_fetcher;

  localparam int AR = 2;
  localparam int KK = 4;
  localparam int BC = 3;

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    int           row;
    int           col;
    bit           last;
  } beat_t;

  logic clk;
  logic rst;
  logic start_v [3];
  logic cm_in   [3];
  logic ready_v [3];
  bit   mode_v  [3];
  bit   rnd_v   [3];
  bit   lat_armed [3];
  int   done_cnt  [3];
  int   hs_cnt    [3];
  int   first_rd  [3];
  beat_t exp_q [3][$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  function automatic int lanes_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
  endfunction

  function automatic logic [31:0] a_val(input int addr);
    return 32'(10 * (addr / KK) + (addr % KK));
  endfunction

  // B stored row-major (B[k][j] at k*BC+j) or column-major (at j*KK+k).
  function automatic logic [31:0] b_val(input int addr, input bit cm);
    int k, j;
    if (cm) begin
      k = addr % KK;
      j = addr / KK;
    end else begin
      k = addr / BC;
      j = addr % BC;
    end
    return 32'(100 * k + j);
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_walk(input int g);
    int ln;
    beat_t e;
    ln = lanes_of(g);
    for (int i = 0; i < AR; i++) begin
      for (int j = 0; j < BC; j++) begin
        for (int kb = 0; kb < KK; kb += ln) begin
          e.a    = '0;
          e.b    = '0;
          e.row  = i;
          e.col  = j;
          e.last = (kb + ln == KK);
          for (int n = 0; n < ln; n++) begin
            e.a[n*32 +: 32] = 32'(10 * i + kb + n);
            e.b[n*32 +: 32] = 32'(100 * (kb + n) + j);
          end
          exp_q[g].push_back(e);
        end
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int q = 0; q < 3; q++) begin
        ready_v[q] = rnd_v[q] ? ($urandom_range(0, 99) < 30) : 1'b1;
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LN = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    logic          busy, done, a_rd_en, b_rd_en, out_valid, out_last;
    logic [2:0]    a_rd_addr;
    logic [3:0]    b_rd_addr;
    logic [31:0]   a_rd_data, b_rd_data;
    logic [LN*32-1:0] out_a, out_b;
    logic          out_row;
    logic [1:0]    out_col;

    matrix_operand_fetcher #(
      .DATA_W (32), .A_ROWS (AR), .K (KK), .B_COLS (BC), .LANES (LN)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start_v[g]),
      .b_col_major (cm_in[g]),
      .busy        (busy),
      .done        (done),
      .a_rd_en     (a_rd_en),
      .a_rd_addr   (a_rd_addr),
      .a_rd_data   (a_rd_data),
      .b_rd_en     (b_rd_en),
      .b_rd_addr   (b_rd_addr),
      .b_rd_data   (b_rd_data),
      .out_valid   (out_valid),
      .out_ready   (ready_v[g]),
      .out_a       (out_a),
      .out_b       (out_b),
      .out_row     (out_row),
      .out_col     (out_col),
      .out_last    (out_last)
    );

    // Memory model: one-cycle read latency, junk when not enabled.
    always @(posedge clk) begin
      a_rd_data <= a_rd_en ? a_val(int'(a_rd_addr)) : $urandom;
      b_rd_data <= b_rd_en ? b_val(int'(b_rd_addr), mode_v[g]) : $urandom;
    end

    // Monitor: scoreboard pop on handshake, stability while stalled, done timing.
    initial begin
      beat_t e;
      bit held;
      int last_hs;
      logic [LN*32-1:0] h_a, h_b;
      logic h_row, h_last;
      logic [1:0] h_col;
      held = 1'b0;
      last_hs = -100;
      forever begin
        @(negedge clk);
        if (rst) begin
          held = 1'b0;
        end else begin
          if (lat_armed[g] && a_rd_en && first_rd[g] < 0) first_rd[g] = cyc;
          if (out_valid) begin
            if (held) begin
              check("hold_stable", 128'({out_a, out_b, out_row, out_col, out_last}),
                    128'({h_a, h_b, h_row, h_col, h_last}));
            end
            if (lat_armed[g] && first_rd[g] >= 0) begin
              check("first_latency", 128'(cyc - first_rd[g]), 128'(LN + 1));
              lat_armed[g] = 1'b0;
            end
            if (ready_v[g]) begin
              hs_cnt[g]++;
              held = 1'b0;
              if (exp_q[g].size() == 0) begin
                check("unexpected_beat", 128'(1), 128'(0));
              end else begin
                e = exp_q[g].pop_front();
                check("beat_a", 128'(out_a), e.a);
                check("beat_b", 128'(out_b), e.b);
                check("beat_tag", 128'({out_row, out_col, out_last}),
                      128'({e.row[0], e.col[1:0], e.last}));
                if (exp_q[g].size() == 0) last_hs = cyc;
              end
            end else begin
              held   = 1'b1;
              h_a    = out_a;
              h_b    = out_b;
              h_row  = out_row;
              h_col  = out_col;
              h_last = out_last;
            end
          end else if (held) begin
            check("valid_dropped", 128'(0), 128'(1));
            held = 1'b0;
          end
          if (done) begin
            done_cnt[g]++;
            check("done_after_last", 128'(cyc - last_hs), 128'(1));
          end
        end
      end
    end
  end

  task automatic kick(input int g, input bit cm);
    @(posedge clk);
    #1;
    cm_in[g]   = cm;
    start_v[g] = 1'b1;
    @(posedge clk);
    #1;
    start_v[g] = 1'b0;
  endtask

  task automatic run_walk(input int g, input bit cm, input bit rnd, input bit poke);
    int d0, t;
    mode_v[g] = cm;
    rnd_v[g]  = rnd;
    push_walk(g);
    d0 = done_cnt[g];
    first_rd[g]  = -1;
    lat_armed[g] = 1'b1;
    kick(g, cm);
    if (poke) begin
      repeat (6) @(posedge clk);
      kick(g, !cm);
      cm_in[g] = cm;
    end
    t = 0;
    while (done_cnt[g] == d0 && t < 4000) begin
      @(posedge clk);
      t++;
    end
    repeat (6) @(posedge clk);
    check("done_once", 128'(done_cnt[g] - d0), 128'(1));
    check("beats_drained", 128'(exp_q[g].size()), 128'(0));
    rnd_v[g] = 1'b0;
  endtask

  initial begin
    int d0, h0, t;
    rst = 1'b1;
    for (int q = 0; q < 3; q++) begin
      start_v[q] = 1'b0; cm_in[q] = 1'b0; ready_v[q] = 1'b1;
      mode_v[q] = 1'b0; rnd_v[q] = 1'b0; lat_armed[q] = 1'b0;
      done_cnt[q] = 0; hs_cnt[q] = 0; first_rd[q] = -1;
    end
    #3;
    check("reset_ctrl", 128'({g_dut[0].busy, g_dut[0].done, g_dut[0].a_rd_en,
          g_dut[0].b_rd_en, g_dut[0].out_valid, g_dut[0].out_last}), 128'(0));
    check("reset_data", 128'({g_dut[0].out_a, g_dut[0].out_b}), 128'(0));
    check("reset_other", 128'({g_dut[1].out_valid, g_dut[2].out_valid,
          g_dut[1].busy, g_dut[2].busy}), 128'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run_walk(0, 1'b0, 1'b0, 1'b0);
    run_walk(0, 1'b1, 1'b0, 1'b0);
    run_walk(0, 1'b0, 1'b1, 1'b0);
    run_walk(0, 1'b1, 1'b1, 1'b0);
    run_walk(1, 1'b0, 1'b0, 1'b0);
    run_walk(1, 1'b1, 1'b1, 1'b0);
    run_walk(2, 1'b0, 1'b0, 1'b0);
    run_walk(2, 1'b1, 1'b1, 1'b0);
    run_walk(0, 1'b0, 1'b0, 1'b1);

    // Reset while beat 5 is in progress, then replay from (0,0).
    mode_v[0] = 1'b0;
    push_walk(0);
    lat_armed[0] = 1'b0;
    d0 = done_cnt[0];
    h0 = hs_cnt[0];
    kick(0, 1'b0);
    t = 0;
    while (hs_cnt[0] < h0 + 4 && t < 500) begin
      @(posedge clk);
      t++;
    end
    check("reached_beat5", 128'(hs_cnt[0] - h0), 128'(4));
    #3 rst = 1'b1;
    #1;
    check("midrst_ctrl", 128'({g_dut[0].busy, g_dut[0].done, g_dut[0].a_rd_en,
          g_dut[0].b_rd_en, g_dut[0].out_valid, g_dut[0].out_last}), 128'(0));
    check("midrst_addr", 128'({g_dut[0].a_rd_addr, g_dut[0].b_rd_addr,
          g_dut[0].out_row, g_dut[0].out_col}), 128'(0));
    check("midrst_data", 128'({g_dut[0].out_a, g_dut[0].out_b}), 128'(0));
    exp_q[0].delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    check("no_done_after_rst", 128'(done_cnt[0] - d0), 128'(0));
    run_walk(0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
